// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, mult/div front-end hold, branch flush.
// Ports: clock/reset (async active-low); fd_insn, dx_insn, branch_taken, md_ready in;
// stall_pc/fd/dx, nop_dx/xm, flush_fd, ctrl_mult/div, md_error, md_busy out.
// Optional STALL_PERF_CNT_EN adds perf_lu_stalls / perf_md_stalls (32-bit, wrapping).
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        stall_pc,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        nop_dx,
    output logic        nop_xm,
    output logic        flush_fd,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        md_error,
    output logic        md_busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_md_stalls
`endif
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_LED  = 5'b01010;
    localparam logic [4:0] OP_CAP  = 5'b01011;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic {MD_IDLE, MD_WAIT} md_state_t;

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [4:0] fd_op, fd_rd, fd_rs1, fd_rs2, fd_alu;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic       fd_r, fd_sw, fd_rd_src;
    logic       use_rs1, use_rs2;
    logic       dx_lw, dx_mul, dx_div;
    logic       lu_hazard;
    logic       md_stall, lu_stall;

    assign fd_op  = fd_insn[31:27];
    assign fd_rd  = fd_insn[26:22];
    assign fd_rs1 = fd_insn[21:17];
    assign fd_rs2 = fd_insn[16:12];
    assign fd_alu = fd_insn[6:2];
    assign dx_op  = dx_insn[31:27];
    assign dx_rd  = dx_insn[26:22];
    assign dx_alu = dx_insn[6:2];

    logic unused_bits;
    assign unused_bits = ^{fd_insn[11:7], fd_insn[1:0],
                           dx_insn[21:7], dx_insn[1:0]};

    assign fd_r  = (fd_op == OP_R);
    assign fd_sw = (fd_op == OP_SW);

    assign use_rs1 = fd_r || fd_sw
                  || (fd_op == OP_ADDI) || (fd_op == OP_LW)
                  || (fd_op == OP_BNE)  || (fd_op == OP_BLT)
                  || (fd_op == OP_BEQ)  || (fd_op == OP_LED)
                  || (fd_op == OP_CAP);

    // sll/sra put a shift amount where rs2 would be
    assign use_rs2 = fd_r && (fd_alu[4:1] != 4'b0010);

    // sw's rd (store data) is left out: W->M bypass covers it
    assign fd_rd_src = (fd_op == OP_BNE) || (fd_op == OP_BLT)
                    || (fd_op == OP_BEQ) || (fd_op == OP_JR)
                    || (fd_op == OP_LED);

    assign dx_lw  = (dx_op == OP_LW);
    assign dx_mul = (dx_op == OP_R) && (dx_alu == ALU_MUL);
    assign dx_div = (dx_op == OP_R) && (dx_alu == ALU_DIV);

    assign lu_hazard = dx_lw && (dx_rd != 5'd0)
                    && ((use_rs1 && (fd_rs1 == dx_rd))
                     || (use_rs2 && (fd_rs2 == dx_rd))
                     || (fd_rd_src && (fd_rd == dx_rd)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_stall  = 1'b0;
        lu_stall  = 1'b0;
        stall_pc  = 1'b0;
        stall_fd  = 1'b0;
        stall_dx  = 1'b0;
        nop_dx    = 1'b0;
        nop_xm    = 1'b0;
        flush_fd  = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        md_error  = 1'b0;
        md_busy   = 1'b0;
        // outputs held low while reset is asserted, whatever the latches hold
        if (reset) begin
            md_busy = (state == MD_WAIT);
            unique case (state)
                MD_IDLE: begin
                    if ((dx_mul || dx_div) && !branch_taken) begin
                        ctrl_mult = dx_mul;
                        ctrl_div  = dx_div;
                        md_stall  = 1'b1;
                        state_nxt = MD_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                MD_WAIT: begin
                    // release cycle: stalls drop so the op moves into X/M
                    if (md_ready) begin
                        state_nxt = MD_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                        md_error  = 1'b1;
                        state_nxt = MD_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        md_stall = 1'b1;
                        cnt_nxt  = (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
                default: state_nxt = MD_IDLE;
            endcase
            if (md_stall) begin
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                stall_dx = 1'b1;
                nop_xm   = 1'b1;
            end else if (branch_taken) begin
                flush_fd = 1'b1;
                nop_dx   = 1'b1;
            end else if (lu_hazard) begin
                lu_stall = 1'b1;
                stall_pc = 1'b1;
                stall_fd = 1'b1;
                nop_dx   = 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_lu_stalls <= '0;
            perf_md_stalls <= '0;
        end else begin
            if (lu_stall)
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (md_stall)
                perf_md_stalls <= perf_md_stalls + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = lu_stall;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
// Output vector order: stall_pc,stall_fd,stall_dx,nop_dx,nop_xm,flush_fd,ctrl_mult,ctrl_div,md_error,md_busy.
module tb_hazard_stall_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_insn, dx_insn;
    logic        branch_taken, md_ready;
    logic        stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd;
    logic        ctrl_mult, ctrl_div, md_error, md_busy;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_md_stalls;
`endif
    logic [9:0]  outs;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_stall_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .fd_insn      (fd_insn),
        .dx_insn      (dx_insn),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .stall_pc     (stall_pc),
        .stall_fd     (stall_fd),
        .stall_dx     (stall_dx),
        .nop_dx       (nop_dx),
        .nop_xm       (nop_xm),
        .flush_fd     (flush_fd),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_error     (md_error),
        .md_busy      (md_busy)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_lu_stalls (perf_lu_stalls),
        .perf_md_stalls (perf_md_stalls)
`endif
    );

    assign outs = {stall_pc, stall_fd, stall_dx, nop_dx, nop_xm,
                   flush_fd, ctrl_mult, ctrl_div, md_error, md_busy};

    localparam logic [9:0] IDLE_V = 10'b00000_00000;
    localparam logic [9:0] LU_V   = 10'b11010_00000;
    localparam logic [9:0] FL_V   = 10'b00010_10000;
    localparam logic [9:0] MST_V  = 10'b11101_01000;
    localparam logic [9:0] DST_V  = 10'b11101_00100;
    localparam logic [9:0] WAIT_V = 10'b11101_00001;
    localparam logic [9:0] REL_V  = 10'b00000_00001;
    localparam logic [9:0] ERR_V  = 10'b00000_00011;

    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_LW  = 5'b01000;

    function automatic logic [31:0] r_ins(
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] alu);
        return {5'b0, rd, rs1, rs2, 5'b0, alu, 2'b0};
    endfunction

    function automatic logic [31:0] i_ins(
        input logic [4:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [16:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic check(input string tag, input logic [9:0] got,
                         input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic vec(input string tag, input logic [31:0] f,
                       input logic [31:0] d, input logic bt,
                       input logic mr, input logic [9:0] exp);
        @(posedge clock);
        #1;
        fd_insn      = f;
        dx_insn      = d;
        branch_taken = bt;
        md_ready     = mr;
        #1;
        check(tag, outs, exp);
    endtask

    logic [31:0] lw_r5, lw_r0, add_dep, add_r0, mul_i, div_i;

    initial begin
        lw_r5   = i_ins(OP_LW, 5'd5, 5'd2, 17'd0);
        lw_r0   = i_ins(OP_LW, 5'd0, 5'd2, 17'd0);
        add_dep = r_ins(5'd7, 5'd5, 5'd3, 5'd0);
        add_r0  = r_ins(5'd1, 5'd0, 5'd0, 5'd0);
        mul_i   = r_ins(5'd4, 5'd2, 5'd3, 5'b00110);
        div_i   = r_ins(5'd4, 5'd2, 5'd3, 5'b00111);

        reset        = 1'b0;
        fd_insn      = add_dep;
        dx_insn      = mul_i;
        branch_taken = 1'b0;
        md_ready     = 1'b0;
        #2;
        check("reset_outs", outs, IDLE_V);

        @(posedge clock);
        #1;
        dx_insn = 32'd0;
        fd_insn = 32'd0;
        reset   = 1'b1;
        #1;
        check("post_reset", outs, IDLE_V);

        vec("lu_stall", add_dep, lw_r5, 0, 0, LU_V);
        vec("lu_after", add_dep, 32'd0, 0, 0, IDLE_V);
        vec("sw_data", i_ins(OP_SW, 5'd5, 5'd6, 17'd4), lw_r5, 0, 0, IDLE_V);
        vec("sw_addr", i_ins(OP_SW, 5'd6, 5'd5, 17'd0), lw_r5, 0, 0, LU_V);
        vec("r0_load", add_r0, lw_r0, 0, 0, IDLE_V);
        vec("sll_rs2", r_ins(5'd1, 5'd3, 5'd5, 5'b00100), lw_r5, 0, 0, IDLE_V);
        vec("bne_rd", i_ins(OP_BNE, 5'd5, 5'd1, 17'd8), lw_r5, 0, 0, LU_V);
        vec("add_rs2", r_ins(5'd7, 5'd3, 5'd5, 5'd0), lw_r5, 0, 0, LU_V);
        vec("flush_pri", add_dep, lw_r5, 1, 0, FL_V);
        vec("flush_mul", 32'd0, mul_i, 1, 0, FL_V);

        vec("mul_start", 32'd0, mul_i, 0, 0, MST_V);
        for (int i = 0; i < 16; i++)
            vec("mul_wait", 32'd0, mul_i, (i == 5), 0, WAIT_V);
        vec("mul_release", 32'd0, mul_i, 0, 1, REL_V);
        vec("mul_after", 32'd0, 32'd0, 0, 0, IDLE_V);

        vec("b2b_start", 32'd0, mul_i, 0, 0, MST_V);
        vec("b2b_wait", 32'd0, mul_i, 0, 0, WAIT_V);
        vec("b2b_release", 32'd0, mul_i, 0, 1, REL_V);
        vec("b2b_restart", 32'd0, mul_i, 0, 0, MST_V);
        vec("b2b_release2", 32'd0, mul_i, 0, 1, REL_V);
        vec("b2b_idle", 32'd0, 32'd0, 0, 0, IDLE_V);

        vec("div_start", 32'd0, div_i, 0, 0, DST_V);
        for (int i = 0; i < 39; i++)
            vec("div_wait", 32'd0, div_i, 0, 0, WAIT_V);
        vec("div_timeout", 32'd0, div_i, 0, 0, ERR_V);
        vec("div_after", 32'd0, 32'd0, 0, 0, IDLE_V);

        vec("div2_start", 32'd0, div_i, 0, 0, DST_V);
        for (int i = 0; i < 10; i++)
            vec("div2_wait", 32'd0, div_i, 0, 0, WAIT_V);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_mid_wait", outs, IDLE_V);
        @(posedge clock);
        #1;
        dx_insn = 32'd0;
        reset   = 1'b1;
        #1;
        check("reset_release", outs, IDLE_V);

        vec("div3_start", 32'd0, div_i, 0, 0, DST_V);
        for (int i = 0; i < 39; i++)
            vec("div3_wait", 32'd0, div_i, 0, 0, WAIT_V);
        vec("div3_timeout", 32'd0, div_i, 0, 0, ERR_V);
        vec("div3_after", 32'd0, 32'd0, 0, 0, IDLE_V);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
